// File: rtl/rank_filter_pkg.sv
// Shared types and compare helper for the rank_filter order-statistic filter.
package rank_filter_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  localparam int MAX_W = 64;

  // Operands arrive already extended to MAX_W, so signed_mode only picks the compare flavour.
  function automatic logic rank_gt(input logic [MAX_W-1:0] a,
                                   input logic [MAX_W-1:0] b,
                                   input logic             signed_mode);
    if (signed_mode) rank_gt = ($signed(a) > $signed(b));
    else             rank_gt = (a > b);
  endfunction

endpackage

// File: rtl/rank_filter_if.sv
// Sample/result bus of rank_filter. DSI/DI/RANK_I flow towards the filter;
// RDY, DO, DSO, ERR and the debug state flow back.
interface rank_filter_if #(
  parameter int DATA_SIZE = 8,
  parameter int N         = 9
);
  import rank_filter_pkg::*;

  // DSI is a strobe with no back-pressure: a sample is taken on any edge where DSI=1
  // and the filter is in IDLE or LOAD; RDY=1 means the next DSI opens a new frame.
  logic                  DSI;
  logic [DATA_SIZE-1:0]  DI;
  logic [$clog2(N)-1:0]  RANK_I;
  logic                  RDY;
  logic [DATA_SIZE-1:0]  DO;
  logic                  DSO;
  logic                  ERR;
  state_t                DBG_STATE;

  modport master (output DSI, DI, RANK_I, input RDY, DO, DSO, ERR, DBG_STATE);
  modport slave  (input DSI, DI, RANK_I, output RDY, DO, DSO, ERR, DBG_STATE);

endinterface

// File: rtl/rank_scan_cell.sv
// Running-maximum tracker: sees one element per cycle and reports the largest valid
// element of the pass (lowest index on ties) together with the pass's last element.
module rank_scan_cell
  import rank_filter_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int N         = 9,
  parameter int SIGNED    = 0,
  parameter int IW        = $clog2(N+1)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 i_en,
  input  logic                 i_last,
  input  logic [DATA_SIZE-1:0] i_elem,
  input  logic                 i_valid,
  input  logic [IW-1:0]        i_pos,
  output logic [DATA_SIZE-1:0] o_cand,
  output logic [IW-1:0]        o_idx
);

  logic [DATA_SIZE-1:0] r_cand;
  logic [IW-1:0]        r_idx;
  logic                 r_have;
  logic                 w_take;

  function automatic logic [MAX_W-1:0] ext(input logic [DATA_SIZE-1:0] x);
    if (SIGNED != 0) ext = {{(MAX_W-DATA_SIZE){x[DATA_SIZE-1]}}, x};
    else             ext = {{(MAX_W-DATA_SIZE){1'b0}}, x};
  endfunction

  // Strict greater-than keeps the earliest index among equal values.
  assign w_take = i_valid && (!r_have || rank_gt(ext(i_elem), ext(r_cand), SIGNED != 0));
  assign o_cand = w_take ? i_elem : r_cand;
  assign o_idx  = w_take ? i_pos  : r_idx;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cand <= '0;
      r_idx  <= '0;
      r_have <= 1'b0;
    end else if (i_en) begin
      if (i_last) begin
        r_have <= 1'b0;
      end else begin
        r_cand <= o_cand;
        r_idx  <= o_idx;
        r_have <= r_have | w_take;
      end
    end
  end

endmodule

// File: rtl/rank_filter.sv
// Order-statistic filter: loads N samples, then removes the maximum N-1-r times
// and returns the next maximum, i.e. the sample of rank r (0 = min).
module rank_filter
  import rank_filter_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int N         = 9,
  parameter int SIGNED    = 0
) (
  input  logic          CLK,
  input  logic          nRST,
  rank_filter_if.slave  bus
);

  localparam int CW = $clog2(N+1);
  localparam int PW = $clog2(N);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_SIZE-1:0] r_mem [N];
  logic [N-1:0]         r_valid;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_i;
  logic [PW-1:0]        r_p;
  logic [PW-1:0]        r_rank;
  logic [DATA_SIZE-1:0] r_do;
  logic                 r_dso;
  logic                 r_err;

  logic [PW-1:0]        w_rank;
  logic                 w_last;
  logic                 w_final;
  logic                 w_load_end;
  logic [DATA_SIZE-1:0] w_cand;
  logic [CW-1:0]        w_idx;

  assign w_rank     = (bus.RANK_I > PW'(N-1)) ? PW'(N-1) : bus.RANK_I;
  assign w_last     = (r_i == CW'(N-1));
  assign w_final    = (r_p == (PW'(N-1) - r_rank));
  assign w_load_end = bus.DSI && (r_cnt == CW'(N-1));

  rank_scan_cell #(
    .DATA_SIZE (DATA_SIZE),
    .N         (N),
    .SIGNED    (SIGNED),
    .IW        (CW)
  ) u_cell (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_en    (r_state == SCAN),
    .i_last  (w_last),
    .i_elem  (r_mem[r_i]),
    .i_valid (r_valid[r_i]),
    .i_pos   (r_i),
    .o_cand  (w_cand),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.DSI) w_state_nxt = LOAD;
      LOAD: begin
        if (!bus.DSI)        w_state_nxt = IDLE;
        else if (w_load_end) w_state_nxt = SCAN;
      end
      SCAN: if (w_last && w_final) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
      r_i     <= '0;
      r_p     <= '0;
      r_rank  <= '0;
      r_do    <= '0;
      r_dso   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dso   <= (r_state == DONE);
      r_err   <= (r_state == LOAD) && !bus.DSI;
      case (r_state)
        IDLE: begin
          if (bus.DSI) begin
            r_rank <= w_rank;
            r_cnt  <= CW'(1);
          end
        end
        LOAD: begin
          if (bus.DSI) r_cnt <= r_cnt + CW'(1);
          if (w_load_end) begin
            r_valid <= '1;
            r_i     <= '0;
            r_p     <= '0;
          end
        end
        SCAN: begin
          if (w_last) begin
            r_i            <= '0;
            r_valid[w_idx] <= 1'b0;
            if (w_final) r_do <= w_cand;
            else         r_p  <= r_p + PW'(1);
          end else begin
            r_i <= r_i + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sample storage needs no reset: the valid vector alone decides what is scanned.
  always_ff @(posedge CLK) begin
    if (bus.DSI) begin
      if (r_state == IDLE)      r_mem[0]     <= bus.DI;
      else if (r_state == LOAD) r_mem[r_cnt] <= bus.DI;
    end
  end

  assign bus.RDY       = (r_state == IDLE);
  assign bus.DO        = r_do;
  assign bus.DSO       = r_dso;
  assign bus.ERR       = r_err;
  assign bus.DBG_STATE = r_state;

endmodule

// File: tb/tb_rank_filter.sv
// Directed bench for rank_filter: an unsigned and a signed instance share every stimulus.
module tb_rank_filter;
  import rank_filter_pkg::*;

  logic CLK;
  logic nRST;
  int   vectors = 0;
  int   miscompares = 0;

  rank_filter_if #(.DATA_SIZE(8), .N(9)) bus_u ();
  rank_filter_if #(.DATA_SIZE(8), .N(9)) bus_s ();

  rank_filter #(.DATA_SIZE(8), .N(9), .SIGNED(0)) dut_u (.CLK(CLK), .nRST(nRST), .bus(bus_u));
  rank_filter #(.DATA_SIZE(8), .N(9), .SIGNED(1)) dut_s (.CLK(CLK), .nRST(nRST), .bus(bus_s));

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [7:0] f_main [9] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
  logic [7:0] f_sgn  [9] = '{8'h7F, 8'h80, 8'hFF, 8'h01, 8'h00, 8'h10, 8'hF0, 8'h02, 8'h03};
  logic [7:0] f_same [9] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
  logic [7:0] f_tie  [9] = '{8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};

  // driver tasks
  task automatic set_in(input logic dsi, input logic [7:0] di, input logic [3:0] rank);
    bus_u.DSI = dsi; bus_u.DI = di; bus_u.RANK_I = rank;
    bus_s.DSI = dsi; bus_s.DI = di; bus_s.RANK_I = rank;
  endtask

  // RANK_I is scrambled after the first sample: only the first one may count.
  task automatic drive_frame(input logic [7:0] v [9], input logic [3:0] rank, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      set_in(1'b1, (k < 9) ? v[k] : 8'hEE, (k == 0) ? rank : ~rank);
      @(posedge CLK); #1;
    end
    set_in(1'b0, 8'h00, 4'd0);
  endtask

  task automatic wait_dso(input int limit, output int lat);
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!bus_u.DSO && lat < limit);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    set_in(1'b0, 8'h00, 4'd0);
    repeat (2) @(posedge CLK);
    #1;
    vectors++; if (bus_u.RDY !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %b exp 1", bus_u.RDY); end
    vectors++; if (bus_u.DO !== 8'h00) begin miscompares++; $display("FAIL reset_do got %h exp 00", bus_u.DO); end
    vectors++; if (bus_u.DSO !== 1'b0 || bus_u.ERR !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got dso=%b err=%b exp 0 0", bus_u.DSO, bus_u.ERR); end
    vectors++; if (bus_u.DBG_STATE !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d exp %0d", bus_u.DBG_STATE, IDLE); end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_median();
    int lat;
    drive_frame(f_main, 4'd4, 9);
    vectors++; if (bus_u.RDY !== 1'b0) begin miscompares++; $display("FAIL median_busy_rdy got %b exp 0", bus_u.RDY); end
    wait_dso(200, lat);
    vectors++; if (lat !== 46) begin miscompares++; $display("FAIL median_lat got %0d exp 46", lat); end
    vectors++; if (bus_u.DO !== 8'd5) begin miscompares++; $display("FAIL median_do got %0d exp 5", bus_u.DO); end
    vectors++; if (bus_u.RDY !== 1'b1) begin miscompares++; $display("FAIL median_rdy got %b exp 1", bus_u.RDY); end
    @(posedge CLK); #1;
    vectors++; if (bus_u.DSO !== 1'b0) begin miscompares++; $display("FAIL median_dso_width got %b exp 0", bus_u.DSO); end
    vectors++; if (bus_u.DO !== 8'd5) begin miscompares++; $display("FAIL median_do_hold got %0d exp 5", bus_u.DO); end
  endtask

  task automatic test_ranks();
    logic [3:0] ranks [3] = '{4'd0, 4'd8, 4'd15};
    int         exp_lat [3] = '{82, 10, 10};
    logic [7:0] exp_do [3] = '{8'd1, 8'd9, 8'd9};
    int         lat;
    for (int k = 0; k < 3; k++) begin
      drive_frame(f_main, ranks[k], 9);
      wait_dso(200, lat);
      vectors++; if (lat !== exp_lat[k]) begin miscompares++; $display("FAIL rank%0d_lat got %0d exp %0d", ranks[k], lat, exp_lat[k]); end
      vectors++; if (bus_u.DO !== exp_do[k]) begin miscompares++; $display("FAIL rank%0d_do got %0d exp %0d", ranks[k], bus_u.DO, exp_do[k]); end
    end
  endtask

  task automatic test_signed();
    int lat;
    drive_frame(f_sgn, 4'd0, 9);
    wait_dso(200, lat);
    vectors++; if (lat !== 82) begin miscompares++; $display("FAIL signed_lat got %0d exp 82", lat); end
    vectors++; if (bus_s.DSO !== 1'b1) begin miscompares++; $display("FAIL signed_dso got %b exp 1", bus_s.DSO); end
    vectors++; if (bus_s.DO !== 8'h80) begin miscompares++; $display("FAIL signed_min got %h exp 80", bus_s.DO); end
    vectors++; if (bus_u.DO !== 8'h00) begin miscompares++; $display("FAIL unsigned_min got %h exp 00", bus_u.DO); end
    drive_frame(f_sgn, 4'd8, 9);
    wait_dso(200, lat);
    vectors++; if (bus_s.DO !== 8'h7F) begin miscompares++; $display("FAIL signed_max got %h exp 7f", bus_s.DO); end
    vectors++; if (bus_u.DO !== 8'hFF) begin miscompares++; $display("FAIL unsigned_max got %h exp ff", bus_u.DO); end
  endtask

  task automatic test_ties();
    logic [3:0] ranks [3] = '{4'd0, 4'd4, 4'd8};
    int         lat;
    for (int k = 0; k < 3; k++) begin
      drive_frame(f_same, ranks[k], 9);
      wait_dso(200, lat);
      vectors++; if (bus_u.DO !== 8'h5A) begin miscompares++; $display("FAIL ties_same_r%0d got %h exp 5a", ranks[k], bus_u.DO); end
    end
    drive_frame(f_tie, 4'd4, 9);
    wait_dso(200, lat);
    vectors++; if (bus_u.DO !== 8'd2) begin miscompares++; $display("FAIL ties_mixed got %0d exp 2", bus_u.DO); end
  endtask

  task automatic test_short_frame();
    int dso_seen = 0;
    int lat;
    drive_frame(f_main, 4'd4, 5);
    @(posedge CLK); #1;
    vectors++; if (bus_u.ERR !== 1'b1) begin miscompares++; $display("FAIL short_err got %b exp 1", bus_u.ERR); end
    vectors++; if (bus_u.RDY !== 1'b1) begin miscompares++; $display("FAIL short_rdy got %b exp 1", bus_u.RDY); end
    @(posedge CLK); #1;
    vectors++; if (bus_u.ERR !== 1'b0) begin miscompares++; $display("FAIL short_err_width got %b exp 0", bus_u.ERR); end
    for (int k = 0; k < 60; k++) begin
      if (bus_u.DSO === 1'b1) dso_seen++;
      @(posedge CLK); #1;
    end
    vectors++; if (dso_seen !== 0) begin miscompares++; $display("FAIL short_no_dso got %0d exp 0", dso_seen); end
    vectors++; if (bus_u.DO !== 8'd2) begin miscompares++; $display("FAIL short_do_kept got %0d exp 2", bus_u.DO); end
    drive_frame(f_main, 4'd4, 9);
    wait_dso(200, lat);
    vectors++; if (lat !== 46 || bus_u.DO !== 8'd5) begin miscompares++; $display("FAIL short_recover got lat=%0d do=%0d exp lat=46 do=5", lat, bus_u.DO); end
  endtask

  task automatic test_reset_mid_scan();
    int dso_seen = 0;
    drive_frame(f_main, 4'd0, 9);
    repeat (20) @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    vectors++; if (bus_u.DO !== 8'h00) begin miscompares++; $display("FAIL rst_scan_do got %h exp 00", bus_u.DO); end
    vectors++; if (bus_u.RDY !== 1'b1 || bus_u.DBG_STATE !== IDLE) begin miscompares++; $display("FAIL rst_scan_idle got rdy=%b state=%0d exp 1 %0d", bus_u.RDY, bus_u.DBG_STATE, IDLE); end
    for (int k = 0; k < 100; k++) begin
      if (bus_u.DSO === 1'b1 || bus_u.ERR === 1'b1) dso_seen++;
      @(posedge CLK); #1;
    end
    vectors++; if (dso_seen !== 0) begin miscompares++; $display("FAIL rst_scan_no_pulse got %0d exp 0", dso_seen); end
  endtask

  task automatic test_long_dsi();
    int lat;
    drive_frame(f_main, 4'd4, 12);
    wait_dso(200, lat);
    vectors++; if (lat !== 43) begin miscompares++; $display("FAIL long_dsi_lat got %0d exp 43", lat); end
    vectors++; if (bus_u.DO !== 8'd5) begin miscompares++; $display("FAIL long_dsi_do got %0d exp 5", bus_u.DO); end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_frame(f_tie, 4'd4, 9);
    wait_dso(200, lat);
    vectors++; if (lat !== 46 || bus_u.DO !== 8'd2) begin miscompares++; $display("FAIL b2b_first got lat=%0d do=%0d exp lat=46 do=2", lat, bus_u.DO); end
    drive_frame(f_main, 4'd8, 9);
    wait_dso(200, lat);
    vectors++; if (lat !== 10 || bus_u.DO !== 8'd9) begin miscompares++; $display("FAIL b2b_second got lat=%0d do=%0d exp lat=10 do=9", lat, bus_u.DO); end
  endtask

  initial begin
    test_reset();
    test_median();
    test_ranks();
    test_signed();
    test_ties();
    test_short_frame();
    test_reset_mid_scan();
    test_long_dsi();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
